// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch responder: fetch states,
// opcode width and the HALT word (opcodes are shared with control).
package instr_fetch_pkg;

  localparam int OPCODE_W    = 3;
  localparam int INSTR_W_DEF = 9;

  // HALT is the all-ones instruction word.
  localparam logic [INSTR_W_DEF-1:0] HALT_WORD = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAPT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch responder: owns the PC, drives a synchronous imem, handles
// branch redirect and HALT. Optional prefetch buffer: INSTR_FETCH_PREFETCH_EN.
//
// state  | meaning
// S_IDLE | no instruction fetched since reset; waiting for next_ins
// S_REQ  | imem_addr driven; imem samples it on this edge
// S_CAPT | imem_rdata valid; capture into instr/pc
// S_HOLD | instr/pc valid and held; waiting for next_ins
// S_HALT | HALT word fetched; absorbing until reset
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 9,
  parameter int RESET_PC = 0
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_next_ins,
  input  logic               i_branch_en,
  input  logic [PC_W-1:0]    i_branch_target,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [INSTR_W-1:0] o_instr,
  output logic [2:0]         o_opcode,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_ins_valid,
  output logic               o_halted
);

  localparam logic [PC_W-1:0]    L_RESET_PC  = PC_W'(RESET_PC);
  localparam logic [INSTR_W-1:0] L_HALT_WORD = {INSTR_W{HALT_WORD[0]}};

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_imem_addr;
  logic [INSTR_W-1:0] r_instr;
  logic               r_ins_valid;
  logic               r_halted;
  logic               r_first;
  logic               r_br_pend;
  logic [PC_W-1:0]    r_br_tgt;

  logic               w_start;
  logic               w_capt;
  logic               w_capt_halt;
  logic [PC_W-1:0]    w_sel_addr;
  logic [PC_W-1:0]    w_pc_inc;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [1:0]         r_pf_stage;
  logic               r_pf_valid;
  logic [INSTR_W-1:0] r_pf_buf;
  logic [PC_W-1:0]    r_pf_addr;
  logic               w_pf_hit;
  logic               w_pf_halt;

  assign w_pf_halt = (r_pf_buf == L_HALT_WORD);
`endif

  assign w_pc_inc    = r_pc + 1'b1;
  assign w_capt_halt = (i_imem_rdata == L_HALT_WORD);

  // Redirect priority: coincident branch, pending branch, first fetch, sequential.
  always_comb begin
    w_sel_addr = w_pc_inc;
    if (i_branch_en) begin
      w_sel_addr = i_branch_target;
    end else if (r_br_pend) begin
      w_sel_addr = r_br_tgt;
    end else if (r_first) begin
      w_sel_addr = L_RESET_PC;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capt      = 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
    w_pf_hit    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_next_ins) begin
          w_start     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_state_nxt = S_CAPT;
      end
      S_CAPT: begin
        w_capt      = 1'b1;
        w_state_nxt = w_capt_halt ? S_HALT : S_HOLD;
      end
      S_HOLD: begin
`ifdef INSTR_FETCH_PREFETCH_EN
        if (i_next_ins && r_pf_valid && !i_branch_en && !r_br_pend) begin
          w_pf_hit    = 1'b1;
          w_state_nxt = w_pf_halt ? S_HALT : S_HOLD;
        end else if (i_next_ins) begin
          w_start     = 1'b1;
          w_state_nxt = S_REQ;
        end
`else
        if (i_next_ins) begin
          w_start     = 1'b1;
          w_state_nxt = S_REQ;
        end
`endif
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc        <= L_RESET_PC;
      r_imem_addr <= L_RESET_PC;
      r_instr     <= '0;
      r_ins_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_first     <= 1'b1;
      r_br_pend   <= 1'b0;
      r_br_tgt    <= '0;
    end else begin
      if (w_start) begin
        r_imem_addr <= w_sel_addr;
        r_ins_valid <= 1'b0;
        r_first     <= 1'b0;
      end
      if (w_capt) begin
        r_instr     <= i_imem_rdata;
        r_pc        <= r_imem_addr;
        r_ins_valid <= 1'b1;
        if (w_capt_halt) begin
          r_halted <= 1'b1;
        end
      end
`ifdef INSTR_FETCH_PREFETCH_EN
      if (w_pf_hit) begin
        r_instr <= r_pf_buf;
        r_pc    <= r_pf_addr;
        if (w_pf_halt) begin
          r_halted <= 1'b1;
        end
      end
      // Launch the next prefetch whenever a fresh non-HALT instruction lands.
      if (w_capt && !w_capt_halt) begin
        r_imem_addr <= r_imem_addr + 1'b1;
      end else if (w_pf_hit && !w_pf_halt) begin
        r_imem_addr <= r_pf_addr + 1'b1;
      end
`endif
      // A coincident branch is consumed by the fetch it accompanies.
      if (w_start) begin
        r_br_pend <= 1'b0;
      end else if (i_branch_en && (r_state != S_HALT)) begin
        r_br_pend <= 1'b1;
        r_br_tgt  <= i_branch_target;
      end
    end
  end

`ifdef INSTR_FETCH_PREFETCH_EN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pf_stage <= 2'd0;
      r_pf_valid <= 1'b0;
      r_pf_buf   <= '0;
      r_pf_addr  <= L_RESET_PC;
    end else begin
      if (w_capt && !w_capt_halt) begin
        r_pf_addr  <= r_imem_addr + 1'b1;
        r_pf_stage <= 2'd1;
        r_pf_valid <= 1'b0;
      end else if (w_pf_hit && !w_pf_halt) begin
        r_pf_addr  <= r_pf_addr + 1'b1;
        r_pf_stage <= 2'd1;
        r_pf_valid <= 1'b0;
      end else if (w_start || w_pf_hit || w_capt) begin
        r_pf_stage <= 2'd0;
        r_pf_valid <= 1'b0;
      end else if (r_pf_stage == 2'd1) begin
        r_pf_stage <= 2'd2;
      end else if (r_pf_stage == 2'd2) begin
        r_pf_buf   <= i_imem_rdata;
        r_pf_valid <= 1'b1;
        r_pf_stage <= 2'd0;
      end
    end
  end
`endif

  assign o_imem_addr = r_imem_addr;
  assign o_instr     = r_instr;
  assign o_opcode    = r_instr[INSTR_W-1 -: OPCODE_W];
  assign o_pc        = r_pc;
  assign o_ins_valid = r_ins_valid;
  assign o_halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a synchronous imem model and an
// expected-fetch scoreboard. Prefetch scenario runs when INSTR_FETCH_PREFETCH_EN is set.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       next_ins;
  logic       branch_en;
  logic [7:0] branch_target;
  logic [7:0] imem_addr;
  logic [8:0] imem_rdata;
  logic [8:0] instr;
  logic [2:0] opcode;
  logic [7:0] pc;
  logic       ins_valid;
  logic       halted;

  int checks   = 0;
  int failures = 0;

  logic [8:0] mem [256];

  typedef struct {
    logic [7:0] addr;
    logic [8:0] word;
  } exp_t;
  exp_t sb[$];

  logic [7:0] m_pc;
  bit         m_first;
  bit         m_pend;
  logic [7:0] m_tgt;
  bit         inflight;

  instr_fetch #(.PC_W(8), .INSTR_W(9), .RESET_PC(0)) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_next_ins     (next_ins),
    .i_branch_en    (branch_en),
    .i_branch_target(branch_target),
    .o_imem_addr    (imem_addr),
    .i_imem_rdata   (imem_rdata),
    .o_instr        (instr),
    .o_opcode       (opcode),
    .o_pc           (pc),
    .o_ins_valid    (ins_valid),
    .o_halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  // next_ins must never be raised while a fetch is in S_REQ/S_CAPT.
  always @(posedge clk) begin
    if (inflight && next_ins) begin
      failures++;
      $display("FAIL protocol: next_ins=%0b during fetch, required 0", next_ins);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_pc    = 8'h00;
    m_first = 1'b1;
    m_pend  = 1'b0;
    m_tgt   = 8'h00;
    sb.delete();
  endtask

  task automatic push_exp(input logic br, input logic [7:0] tgt);
    exp_t e;
    if (br)           e.addr = tgt;
    else if (m_pend)  e.addr = m_tgt;
    else if (m_first) e.addr = 8'h00;
    else              e.addr = m_pc + 8'h01;
    e.word  = mem[e.addr];
    m_pc    = e.addr;
    m_pend  = 1'b0;
    m_first = 1'b0;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty when output appeared", nm);
    end else begin
      e = sb.pop_front();
      checks++;
      if (pc !== e.addr) begin
        failures++;
        $display("FAIL %s_pc: got %h, required %h", nm, pc, e.addr);
      end
      checks++;
      if (instr !== e.word) begin
        failures++;
        $display("FAIL %s_instr: got %h, required %h", nm, instr, e.word);
      end
      checks++;
      if (opcode !== e.word[8:6]) begin
        failures++;
        $display("FAIL %s_opcode: got %b, required %b", nm, opcode, e.word[8:6]);
      end
    end
  endtask

  // Normal 2-cycle fetch: next_ins at E0, ins_valid after E2.
  task automatic do_fetch(input logic br, input logic [7:0] tgt, input string nm);
    @(negedge clk);
    next_ins = 1'b1; branch_en = br; branch_target = tgt;
    push_exp(br, tgt);
    @(posedge clk); #1;
    next_ins = 1'b0; branch_en = 1'b0;
    inflight = 1'b1;
    checks++;
    if (imem_addr !== sb[sb.size()-1].addr) begin
      failures++;
      $display("FAIL %s_addr: got %h, required %h", nm, imem_addr, sb[sb.size()-1].addr);
    end
    checks++;
    if (ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid_e0: got %b, required 0", nm, ins_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid_e1: got %b, required 0", nm, ins_valid);
    end
    @(posedge clk); #1;
    inflight = 1'b0;
    checks++;
    if (ins_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid_e2: got %b, required 1", nm, ins_valid);
    end
    pop_check(nm);
  endtask

  task automatic pulse_branch(input logic [7:0] tgt);
    @(negedge clk);
    branch_en = 1'b1; branch_target = tgt;
    @(negedge clk);
    branch_en = 1'b0;
    m_pend = 1'b1;
    m_tgt  = tgt;
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if (imem_addr !== 8'h00 || pc !== 8'h00 || instr !== 9'h000 ||
        ins_valid !== 1'b0 || halted !== 1'b0 || opcode !== 3'b000) begin
      failures++;
      $display("FAIL %s: got addr=%h pc=%h instr=%h valid=%b halted=%b op=%b, required 00 00 000 0 0 000",
               nm, imem_addr, pc, instr, ins_valid, halted, opcode);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_idle");
  endtask

  task automatic test_first_fetch();
    do_fetch(1'b0, 8'h00, "first");
    checks++;
    if (opcode !== 3'b000) begin
      failures++;
      $display("FAIL first_op_const: got %b, required 000", opcode);
    end
  endtask

  task automatic test_sequential();
    do_fetch(1'b0, 8'h00, "seq1");
    do_fetch(1'b1, 8'hFF, "to_ff");
    do_fetch(1'b0, 8'h00, "wrap");
  endtask

  task automatic test_branch();
    pulse_branch(8'h40);
    repeat (2) @(negedge clk);
    do_fetch(1'b0, 8'h00, "br40");
    do_fetch(1'b0, 8'h00, "br41");
    pulse_branch(8'h10);
    pulse_branch(8'h20);
    do_fetch(1'b0, 8'h00, "br_ovr");
  endtask

  task automatic test_reset_mid_fetch();
    pulse_branch(8'h30);
    @(negedge clk);
    next_ins = 1'b1;
    @(posedge clk); #1;
    next_ins = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(1'b0, 8'h00, "post_reset");
  endtask

  task automatic test_halt();
    do_fetch(1'b1, 8'h05, "halt_fetch");
    checks++;
    if (halted !== 1'b1 || opcode !== 3'b111) begin
      failures++;
      $display("FAIL halt_flag: got halted=%b op=%b, required 1 111", halted, opcode);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      next_ins = 1'b1; branch_en = i[0]; branch_target = 8'h77;
      @(posedge clk); #1;
      next_ins = 1'b0; branch_en = 1'b0;
      checks++;
      if (pc !== 8'h05 || imem_addr !== 8'h05 || instr !== HALT_WORD ||
          ins_valid !== 1'b1 || halted !== 1'b1) begin
        failures++;
        $display("FAIL halt_hold%0d: got pc=%h addr=%h instr=%h valid=%b halted=%b, required 05 05 1ff 1 1",
                 i, pc, imem_addr, instr, ins_valid, halted);
      end
    end
  endtask

`ifdef INSTR_FETCH_PREFETCH_EN
  task automatic test_prefetch();
    exp_t e;
    do_fetch(1'b0, 8'h00, "pf_first");
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (ins_valid !== 1'b1) begin
          failures++;
          $display("FAIL pf_wait%0d_%0d: ins_valid=%b, required 1", k, c, ins_valid);
        end
      end
      next_ins = 1'b1;
      e.addr = m_pc + 8'h01;
      e.word = mem[e.addr];
      m_pc   = e.addr;
      sb.push_back(e);
      @(posedge clk); #1;
      next_ins = 1'b0;
      checks++;
      if (ins_valid !== 1'b1) begin
        failures++;
        $display("FAIL pf_hit%0d_valid: got %b, required 1", k, ins_valid);
      end
      pop_check("pf_hit");
    end
    repeat (2) @(negedge clk);
    do_fetch(1'b1, 8'h40, "pf_branch");
  endtask
`endif

  initial begin
    next_ins = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
    inflight = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 9'((i * 7 + 3) % 511);
    mem[8'h00] = 9'h012;
    mem[8'h01] = 9'h0A5;
    mem[8'h05] = HALT_WORD;
    mem[8'h20] = 9'h0C7;
    mem[8'h40] = 9'h155;
    mem[8'h41] = 9'h0F0;
    mem[8'hFF] = 9'h1C3;
    #1;
    test_reset();
`ifdef INSTR_FETCH_PREFETCH_EN
    test_prefetch();
`else
    test_first_fetch();
    test_sequential();
    test_branch();
    test_reset_mid_fetch();
    test_halt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
